// File: rtl/dcm_ctrl_pkg.sv
// Shared definitions for the clock-manager programming path: code width,
// named frequency codes, FSM state encoding and a small sizing helper.
package dcm_ctrl_pkg;

  localparam int PROG_W = 3;

  localparam logic [PROG_W-1:0] PROG_X1   = 3'd0;
  localparam logic [PROG_W-1:0] PROG_X2   = 3'd1;
  localparam logic [PROG_W-1:0] PROG_X4   = 3'd2;
  localparam logic [PROG_W-1:0] PROG_X10  = 3'd3;
  localparam logic [PROG_W-1:0] PROG_X16  = 3'd4;
  localparam logic [PROG_W-1:0] PROG_X32  = 3'd5;
  localparam logic [PROG_W-1:0] PROG_X64  = 3'd6;
  localparam logic [PROG_W-1:0] PROG_X128 = 3'd7;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SETUP   = 2'd1;
  localparam state_t ST_PULSE   = 2'd2;
  localparam state_t ST_HOLDOFF = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dcm_prog_arbiter_rr.sv
// Combinational round-robin pick: first eligible index after the pointer,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   pointer,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  // Scan farthest-first so the nearest eligible index after the pointer wins.
  always_comb begin
    int cand;
    // NOTE: every output gets a default before the loop, otherwise synthesis infers latches.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(pointer) + k) % NUM_REQ;
      if (eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/dcm_prog_arbiter.sv
// Shares the clock manager's programming port between NUM_REQ requesters and
// drives a setup / pulse / holdoff update sequence for each granted code change.
module dcm_prog_arbiter
  import dcm_ctrl_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int SETUP_CYCLES   = 2,
  parameter  int PULSE_CYCLES   = 4,
  parameter  int HOLDOFF_CYCLES = 16,
  localparam int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [PROG_W*NUM_REQ-1:0] req_prog,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic [PROG_W-1:0]         prog_out,
  output logic                      update_out,
  output logic [PROG_W-1:0]         cur_prog
);

  localparam int CNT_W = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, HOLDOFF_CYCLES) + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [PROG_W-1:0]   prog_q, prog_d;
  logic                upd_q, upd_d;
  logic [PROG_W-1:0]   cur_q, cur_d;

  logic [NUM_REQ-1:0]  eligible;
  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;
  logic [PROG_W-1:0]   win_code;

  // A requester being acked this cycle must not be re-granted before it drops req.
  assign eligible = req & ~ack_q;
  assign win_code = req_prog[grant_idx*PROG_W +: PROG_W];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .eligible    (eligible),
    .pointer     (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_d   = '0;
    prog_d  = prog_q;
    upd_d   = upd_q;
    cur_d   = cur_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          grant_d = grant_idx;
          ptr_d   = grant_idx;
          if (win_code == cur_q) begin
            ack_d[grant_idx] = 1'b1;
          end else begin
            prog_d  = win_code;
            state_d = ST_SETUP;
            cnt_d   = CNT_W'(SETUP_CYCLES);
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_PULSE;
          cnt_d   = CNT_W'(PULSE_CYCLES);
          upd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d        = ST_HOLDOFF;
          cnt_d          = CNT_W'(HOLDOFF_CYCLES);
          upd_d          = 1'b0;
          ack_d[grant_q] = 1'b1;
          cur_d          = prog_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Reset is shared with the clock manager, so both restart agreeing on code 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      prog_q  <= '0;
      upd_q   <= 1'b0;
      cur_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      prog_q  <= prog_d;
      upd_q   <= upd_d;
      cur_q   <= cur_d;
    end
  end

  assign ack        = ack_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign prog_out   = prog_q;
  assign update_out = upd_q;
  assign cur_prog   = cur_q;

endmodule

// File: tb/tb_dcm_prog_arbiter.sv
// Scoreboard bench for dcm_prog_arbiter: stimulus pushes expected acks,
// a negedge monitor pops and compares them when the DUT pulses ack.
module tb_dcm_prog_arbiter;

  localparam int NUM_REQ = 4;

  logic                  clock;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [3*NUM_REQ-1:0]  req_prog;
  logic [NUM_REQ-1:0]    ack;
  logic                  busy;
  logic [1:0]            grant_id;
  logic [2:0]            prog_out;
  logic                  update_out;
  logic [2:0]            cur_prog;

  typedef struct {
    int idx;
    int code;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   c0;

  dcm_prog_arbiter #(
    .NUM_REQ(NUM_REQ), .SETUP_CYCLES(2), .PULSE_CYCLES(4), .HOLDOFF_CYCLES(16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_prog   (req_prog),
    .ack        (ack),
    .busy       (busy),
    .grant_id   (grant_id),
    .prog_out   (prog_out),
    .update_out (update_out),
    .cur_prog   (cur_prog)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every ack pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && ack != '0) begin
      check("ack_onehot", $countones(ack), 1);
      if (sb.size() == 0) begin
        check("ack_unexpected", ack, 0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_idx", ack, 1 << mon_e.idx);
        check("ack_cycle", cyc, mon_e.cyc);
        check("ack_grant_id", grant_id, mon_e.idx);
        check("ack_cur_prog", cur_prog, mon_e.code);
      end
    end
  end

  task automatic pulse_reset();
    reset = 1'b1;
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_prog = '0;
    repeat (2) @(negedge clock);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_prog_out", prog_out, 0);
    check("rst_update_out", update_out, 0);
    check("rst_cur_prog", cur_prog, 0);
    reset = 1'b0;
    @(negedge clock);

    // Single request: code 3 from requester 0.
    c0       = cyc;
    req_prog = 12'd3;
    req      = 4'b0001;
    sb.push_back('{0, 3, c0 + 7});
    for (int k = 1; k <= 24; k++) begin
      @(negedge clock);
      check("A_prog_out", prog_out, 3);
      check("A_update_out", update_out, (k >= 3 && k <= 6));
      check("A_busy", busy, (k <= 22));
      req = req & ~ack;
    end
    check("A_sb_drained", sb.size(), 0);

    // Same code from requester 1: ack next cycle, no update pulse.
    c0       = cyc;
    req_prog = 12'd3 << 3;
    req      = 4'b0010;
    sb.push_back('{1, 3, c0 + 1});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      check("B_update_out", update_out, 0);
      check("B_busy", busy, 0);
      check("B_prog_out", prog_out, 3);
      req = req & ~ack;
    end
    check("B_sb_drained", sb.size(), 0);

    // Contention after reset: all four request, served 0..3, 23 cycles apart.
    pulse_reset();
    c0       = cyc;
    req_prog = {3'd7, 3'd4, 3'd2, 3'd1};
    req      = 4'b1111;
    for (int i = 0; i < 4; i++) sb.push_back('{i, (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 4 : 7, c0 + 7 + 23 * i});
    for (int k = 1; k <= 95; k++) begin
      @(negedge clock);
      req = req & ~ack;
    end
    check("C_cur_prog", cur_prog, 7);
    check("C_all_served", req, 0);
    check("C_busy", busy, 0);
    check("C_sb_drained", sb.size(), 0);

    // Requester 2 drops req during SETUP: sequence and ack still complete.
    c0       = cyc;
    req_prog = 12'd5 << 6;
    req      = 4'b0100;
    sb.push_back('{2, 5, c0 + 7});
    for (int k = 1; k <= 28; k++) begin
      @(negedge clock);
      check("D_update_out", update_out, (k >= 3 && k <= 6));
      check("D_busy", busy, (k <= 22));
      if (k == 1) req = 4'b0000;
    end
    check("D_cur_prog", cur_prog, 5);
    check("D_sb_drained", sb.size(), 0);

    // Reset mid-pulse clears outputs without waiting for a clock edge.
    c0       = cyc;
    req_prog = 12'd1 << 3;
    req      = 4'b0010;
    sb.push_back('{1, 1, c0 + 7});
    repeat (4) @(negedge clock);
    check("E_in_pulse", update_out, 1);
    #2;
    reset = 1'b1;
    #1;
    check("E_async_update_out", update_out, 0);
    check("E_async_prog_out", prog_out, 0);
    check("E_async_cur_prog", cur_prog, 0);
    check("E_async_busy", busy, 0);
    req = '0;
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // After reset the pointer favours requester 0 over requester 2.
    c0       = cyc;
    req_prog = {3'd0, 3'd6, 3'd0, 3'd2};
    req      = 4'b0101;
    sb.push_back('{0, 2, c0 + 7});
    sb.push_back('{2, 6, c0 + 30});
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock);
      req = req & ~ack;
    end
    check("F_cur_prog", cur_prog, 6);
    check("F_sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcm_prog_arbiter.md
Name: dcm_prog_arbiter

Overview:
- Shares the programming port of the digital clock manager (prog_in, update_clock) between NUM_REQ requesters.
- Each requester asks for a 3-bit frequency code. The block picks one requester by round-robin.
- It then drives a clean update sequence (setup, pulse, holdoff) into the clock manager and acknowledges the winner.
- It sits between the system control logic (switch debouncers, host registers) and the clock manager. It shares reset with the clock manager, so both agree on code 0 after reset.

Parameters:
- NUM_REQ, 4: number of requesters, minimum 2.
- SETUP_CYCLES, 2: cycles prog_in is stable before update_clock rises, minimum 1.
- PULSE_CYCLES, 4: update_clock high time in cycles, minimum 1.
- HOLDOFF_CYCLES, 16: cycles after the pulse during which prog_in stays stable and no new grant is made, minimum 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- req  in  NUM_REQ  level request per requester; held until the matching ack.
- req_prog  in  3*NUM_REQ  packed codes; bits [3i+2:3i] belong to requester i.
- ack  out  NUM_REQ  one-cycle pulse to the served requester.
- busy  out  1  high whenever the FSM is not in IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- prog_out  out  3  drives the clock manager's prog_in.
- update_out  out  1  drives the clock manager's update_clock.
- cur_prog  out  3  last code actually applied.

Behaviour:
- Reset values: all outputs are registered and reset to 0 (ack, busy, grant_id, prog_out, update_out, cur_prog).
  - The round-robin pointer resets to NUM_REQ-1, so requester 0 has first priority.
  - Reset is asynchronous. Asserting it mid-sequence forces update_out low immediately and returns the FSM to IDLE.
- FSM states: IDLE, SETUP, PULSE, HOLDOFF. A single down-counter serves all states; its width is sized for the largest of the three cycle parameters.
- IDLE:
  - Requester eligibility: req[i]=1 and ack[i]=0 in the same cycle. This mask stops a requester that was just acked from being re-granted before it drops req.
  - Winner: the first eligible index after the last grant, wrapping modulo NUM_REQ.
  - Winning a grant latches the winner's code and updates grant_id and the pointer.
  - If the code equals cur_prog, the next cycle pulses ack[winner], makes no update pulse, and the FSM stays in IDLE.
  - Otherwise the FSM goes to SETUP with counter = SETUP_CYCLES.
  - With no eligible request, outputs hold and prog_out equals cur_prog.
- Timing, taking the IDLE sample cycle as cycle 0:
  - Cycles 1..S (SETUP): prog_out = new code, update_out = 0.
  - Cycles S+1..S+P (PULSE): update_out = 1, prog_out stable.
  - Cycle S+P+1 (first HOLDOFF cycle): update_out = 0, ack[winner] = 1, cur_prog <= code.
  - HOLDOFF lasts H cycles, prog_out stable throughout.
  - Cycle S+P+H+1: FSM is back in IDLE and may sample the next request.
  - Service interval per grant: S+P+H+1 cycles.
- Request dropped mid-sequence: the sequence completes and ack is still pulsed; the requester ignores it.
- req_prog changes after the grant: ignored, since the code was latched.
- Simultaneous requests: exactly one grant per interval. Fairness guarantees each active requester a grant within NUM_REQ intervals.
- ack is never asserted on more than one bit at a time.

Decomposition:
- Package dcm_ctrl_pkg holds:
  - PROG_W=3.
  - Code constants PROG_X1=0, X2=1, X4=2, X10=3, X16=4, X32=5, X64=6, X128=7.
  - The FSM state typedef.
- Sub-module rr_arbiter(NUM_REQ):
  - Combinational grant from the eligible vector and the pointer.
  - Outputs grant_valid and grant_idx.
  - The pointer register stays in the parent.

Test Plan (defaults S=2, P=4, H=16):
- Single request, req[0]=1, code 3 at cycle 0 -> prog_out=3 from cycle 1; update_out high cycles 3-6; ack[0] and cur_prog=3 at cycle 7; busy low at cycle 23.
- Same-code request, cur_prog=3, req[1] with code 3 -> ack[1] at cycle 1; update_out never rises; busy stays 0.
- Contention, all four req high after reset with codes 1, 2, 4, 7 -> grants in order 0, 1, 2, 3, 23 cycles apart; cur_prog ends at 7; no double acks.
- req[2] dropped during SETUP -> pulse still issued, ack[2] still pulses, no re-grant of requester 2.
- Reset asserted during PULSE -> update_out, prog_out and cur_prog go to 0 without waiting for a clock edge; after release, requester 0 has priority again.
- Integration with the clock manager (small COUNT_10): program code 2 -> slow clock half-period becomes 4x the base half-period within one period after the ack.
